// File: rtl/record_fifo_pkg.sv
// Shared helpers for record_fifo: width derivations used by the top and the packer.
package record_fifo_pkg;

    function automatic int count_w(input int record_words);
        return $clog2(record_words + 1);
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/record_fifo_packer.sv
// Assembles incoming words into a record and strobes commit on the closing word.
module record_packer
    import record_fifo_pkg::*;
#(
    parameter  int WordSize    = 8,
    parameter  int RecordWords = 16,
    localparam int CountW      = count_w(RecordWords),
    localparam int RecordBits  = WordSize * RecordWords
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [WordSize-1:0]   data_i,
    input  logic                  last_i,
    output logic [RecordBits-1:0] rec_o,
    output logic [CountW-1:0]     words_o,
    output logic                  commit_o
);

    logic [CountW-1:0]   pack_cnt_q, pack_cnt_d;
    logic [WordSize-1:0] asm_q [RecordWords];
    logic                last_slot;

    assign last_slot = (pack_cnt_q == CountW'(RecordWords - 1));
    assign commit_o  = accept_i && !clear_i && (last_i || last_slot);
    assign words_o   = pack_cnt_q + CountW'(1);

    always_comb begin
        pack_cnt_d = pack_cnt_q;
        if (clear_i) begin
            pack_cnt_d = '0;
        end else if (accept_i) begin
            pack_cnt_d = commit_o ? '0 : pack_cnt_q + CountW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_cnt_q <= '0;
        end else begin
            pack_cnt_q <= pack_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < RecordWords; k++) begin
            if (accept_i && pack_cnt_q == CountW'(k)) begin
                asm_q[k] <= data_i;
            end
        end
    end

    // Words past the current position are masked to zero, so stale assembly
    // contents left by a clear or reset can never leak into a record.
    always_comb begin
        rec_o = '0;
        for (int k = 0; k < RecordWords; k++) begin
            if (CountW'(k) == pack_cnt_q) begin
                rec_o[k*WordSize +: WordSize] = data_i;
            end else if (CountW'(k) < pack_cnt_q) begin
                rec_o[k*WordSize +: WordSize] = asm_q[k];
            end
        end
    end

endmodule

// File: rtl/record_fifo.sv
// Word-in / record-out FIFO with first-word-fall-through output and level flags.
module record_fifo
    import record_fifo_pkg::*;
#(
    parameter  int WordSize            = 8,
    parameter  int RecordWords         = 16,
    parameter  int Depth               = 8,
    parameter  int AlmostFullThreshold = Depth - 1,
    localparam int RecordBits          = WordSize * RecordWords,
    localparam int CountW              = count_w(RecordWords),
    localparam int LevelW              = level_w(Depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WordSize-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RecordBits-1:0] out_data,
    output logic [CountW-1:0]     out_words,
    output logic [LevelW-1:0]     rec_count,
    output logic                  almost_full,
    output logic                  empty
);

    logic [LevelW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [LevelW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [RecordBits+CountW-1:0] mem_q [Depth];
    logic [RecordBits+CountW-1:0] head;
    logic [RecordBits-1:0]        pk_rec;
    logic [CountW-1:0]            pk_words;
    logic                         pk_commit;
    logic                         accept;
    logic                         pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    record_packer #(
        .WordSize    (WordSize),
        .RecordWords (RecordWords)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .accept_i (accept),
        .data_i   (in_data),
        .last_i   (in_last),
        .rec_o    (pk_rec),
        .words_o  (pk_words),
        .commit_o (pk_commit)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign rec_count   = wr_ptr_q - rd_ptr_q;
    assign in_ready    = (rec_count != LevelW'(Depth));
    assign empty       = (rec_count == '0);
    assign almost_full = (rec_count >= LevelW'(AlmostFullThreshold));
    assign out_valid   = !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (pk_commit) wr_ptr_d = wr_ptr_q + LevelW'(1);
            if (pop)       rd_ptr_d = rd_ptr_q + LevelW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pk_commit) begin
            mem_q[wr_ptr_q[LevelW-2:0]] <= {pk_rec, pk_words};
        end
    end

    assign head      = mem_q[rd_ptr_q[LevelW-2:0]];
    assign out_data  = out_valid ? head[CountW +: RecordBits] : '0;
    assign out_words = out_valid ? head[CountW-1:0] : '0;

endmodule

// File: tb/tb_record_fifo.sv
// Directed bench for record_fifo at default parameters (8-bit words, 16 words/record, 8 slots).
module tb_record_fifo;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_words;
    logic [3:0]   rec_count;
    logic         almost_full;
    logic         empty;

    typedef struct {
        logic [127:0] d;
        logic [4:0]   w;
    } rec_t;

    rec_t         sb[$];
    rec_t         r;
    int           n_checks = 0;
    int           n_errors = 0;
    int           sent;
    int           cnt;
    int           maxc;
    logic [127:0] asmb;
    logic [127:0] exp_rec;
    logic [7:0]   d;
    logic         l;

    always #5 clk = ~clk;

    record_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_words   (out_words),
        .rec_count   (rec_count),
        .almost_full (almost_full),
        .empty       (empty)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] data, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (!in_ready) check("push_timeout", in_ready, 1);
        else step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [127:0] data, input logic [4:0] words);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, data);
        check({tag, "_words"}, out_words, words);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_words"}, out_words, 0);
        check({tag, "_rec_count"}, rec_count, 0);
        check({tag, "_almost_full"}, almost_full, 0);
        check({tag, "_empty"}, empty, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        check_idle("reset");
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Full 16-word record 0x00..0x0F
        for (int i = 0; i < 15; i++) push(8'(i), 1'b0);
        check("pre_commit_out_valid", out_valid, 0);
        push(8'h0F, 1'b0);
        check("commit_out_valid", out_valid, 1);
        check("commit_word0", out_data[7:0], 8'h00);
        check("commit_word15", out_data[127:120], 8'h0F);
        check("commit_rec_count", rec_count, 1);
        pop_expect("full16", 128'h0F0E0D0C0B0A09080706050403020100, 5'd16);
        check("full16_empty", empty, 1);

        // Early close with zero padding
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b1);
        pop_expect("short3", 128'hA3A2A1, 5'd3);

        // Fill all eight slots, hold the 129th word off, then pop once
        for (int i = 0; i < 128; i++) begin
            push(8'(i), 1'b0);
            if (i == 95) check("af_at6", almost_full, 0);
            if (i == 111) begin
                check("af_at7", almost_full, 1);
                check("count_at7", rec_count, 7);
            end
        end
        check("full_count", rec_count, 8);
        check("full_in_ready", in_ready, 0);
        check("full_af", almost_full, 1);
        in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0;
        repeat (3) step();
        check("full_hold_count", rec_count, 8);
        check("full_head", out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after_pop_in_ready", in_ready, 1);
        check("after_pop_count", rec_count, 7);
        step();
        in_valid = 1'b0;
        check("word129_no_commit", rec_count, 7);
        for (int rr = 1; rr < 8; rr++) begin
            for (int k = 0; k < 16; k++) exp_rec[k*8 +: 8] = 8'(rr*16 + k);
            pop_expect("drain", exp_rec, 5'd16);
        end
        push(8'hEF, 1'b1);
        pop_expect("word129", 128'hEFEE, 5'd2);

        // Streaming with both handshakes held high and random record closes
        sent = 0; cnt = 0; maxc = 0; asmb = '0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && (sent < 1000 || sb.size() > 0 || out_valid); cyc++) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("rand_spurious", out_valid, 0);
                end else begin
                    r = sb.pop_front();
                    check("rand_rec", {out_words, out_data}, {r.w, r.d});
                end
            end
            if (int'(rec_count) > maxc) maxc = int'(rec_count);
            if (sent < 1000 && in_ready) begin
                d = 8'($urandom);
                l = ($urandom_range(0, 7) == 0) || (sent == 999);
                in_valid = 1'b1; in_data = d; in_last = l;
                asmb[cnt*8 +: 8] = d;
                cnt++; sent++;
                if (l || cnt == 16) begin
                    sb.push_back('{asmb, 5'(cnt)});
                    asmb = '0;
                    cnt = 0;
                end
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            step();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        check("rand_sent", sent, 1000);
        check("rand_sb_left", sb.size(), 0);
        check("rand_max_count_ok", maxc <= 8, 1);
        check("rand_empty", empty, 1);

        // Synchronous clear with a same-cycle accept
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        for (int i = 0; i < 4; i++) push(8'(8'h61 + i), 1'b0);
        in_valid = 1'b1; in_data = 8'h65; clear = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_count", rec_count, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_empty", empty, 1);
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
        pop_expect("clr_next", 128'h1F1E1D1C1B1A19181716151413121110, 5'd16);

        // Asynchronous reset in the middle of a record
        push(8'h09, 1'b1);
        for (int i = 0; i < 5; i++) push(8'(8'h71 + i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        step();
        rst_n = 1'b1;
        push(8'h81, 1'b0);
        push(8'h82, 1'b1);
        pop_expect("rst_next", 128'h8281, 5'd2);

        // Commit and pop on the same edge at rec_count 4
        push(8'h31, 1'b1);
        push(8'h32, 1'b1);
        push(8'h33, 1'b1);
        push(8'h34, 1'b1);
        check("sim_count_before", rec_count, 4);
        push(8'h35, 1'b0);
        in_valid = 1'b1; in_data = 8'h36; in_last = 1'b1; out_ready = 1'b1;
        check("sim_head_data", out_data, 128'h31);
        check("sim_head_words", out_words, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        check("sim_count_after", rec_count, 4);
        pop_expect("sim_r32", 128'h32, 5'd1);
        pop_expect("sim_r33", 128'h33, 5'd1);
        pop_expect("sim_r34", 128'h34, 5'd1);
        pop_expect("sim_r3635", 128'h3635, 5'd2);
        check("sim_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/record_fifo.md
# record_fifo

Parametrised successor to the word-in/record-out fifo. It accepts one word per handshake, packs `RecordWords` words into a record, and stores up to `Depth` records. Records are presented as a first-word-fall-through output with a valid/ready handshake. Adds asynchronous reset, synchronous clear, early record close (`in_last`) with zero padding and a per-record word count, an almost-full flag and a record-level count. It sits between the byte-stream receiver and the record consumer.

## Interface
Parameters:
- `WordSize`, 8, bits per input word
- `RecordWords`, 16, words per full record; ≥1, power of 2
- `Depth`, 8, record slots; ≥2, power of 2
- `AlmostFullThreshold`, `Depth-1`, `almost_full` asserts when `rec_count` ≥ this; 1..`Depth`
- Derived: `RecordBits = WordSize*RecordWords`, `CountW = $clog2(RecordWords+1)`, `LevelW = $clog2(Depth)+1`

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `clear` in 1: synchronous flush of storage and the partial record
- `in_valid` in 1: input word offered
- `in_ready` out 1: input word accepted when high together with `in_valid`
- `in_data` in `WordSize`: input word
- `in_last` in 1: closes the current record with this word
- `out_valid` out 1: head record available
- `out_ready` in 1: consumer takes the head record
- `out_data` out `RecordBits`: head record; word k at bits `[(k+1)*WordSize-1 : k*WordSize]`
- `out_words` out `CountW`: valid words in the head record, 1..`RecordWords`
- `rec_count` out `LevelW`: committed records held, 0..`Depth`
- `almost_full` out 1: `rec_count` ≥ `AlmostFullThreshold`
- `empty` out 1: `rec_count` == 0

## Operation
- Handshakes: a word is accepted when `in_valid && in_ready`; a record is popped when `out_valid && out_ready`. `in_valid` and `out_ready` may be held high indefinitely.
- Packing: accepted words fill the assembly register from word 0 upward. `pack_cnt` counts 0..`RecordWords-1`.
- Commit: a record is written to slot `wr_ptr` on the edge that accepts either the `RecordWords`-th word or any word with `in_last=1`.
  - Unfilled words are written as zero.
  - `out_words = pack_cnt+1` for the committed record.
  - `pack_cnt` returns to 0.
- `in_last` on the `RecordWords`-th word produces one full record, not an extra empty one. Empty records cannot occur.
- `in_ready = (rec_count != Depth)`. No word is accepted while storage is full, even if the word would not complete a record. A pop in the same cycle does not raise `in_ready` combinationally.
- Pointers are `LevelW` bits wide and wrap modulo `2*Depth`. `rec_count = wr_ptr - rd_ptr`, computed modulo 2^`LevelW`. Slot index is `ptr[LevelW-2:0]`.
- Output path: `out_valid = !empty`. `out_data`/`out_words` come combinationally from slot `rd_ptr` and are forced to 0 when `out_valid=0`.
- Simultaneous commit and pop: `rec_count` is unchanged; both pointers advance.
- `clear` has priority over any same-cycle accept or pop. It zeroes `wr_ptr`, `rd_ptr` and `pack_cnt`, and discards the partial record. Storage contents are not cleared.
- Reset (`rst_n` low, any time, including mid-record): same effect as `clear`, applied asynchronously.
  - Outputs after reset: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_words=0`, `rec_count=0`, `almost_full=0`, `empty=1`.

## Timing
- Commit latency: a word completing a record is accepted at edge N; `out_valid` is high from edge N onward, i.e. visible in cycle N+1.
- Pop: `rd_ptr` advances at the accepting edge; the next record (if any) is presented in the following cycle. Sustained throughput is one record per cycle.
- Full: a pop at edge N drops `rec_count` to `Depth-1`, so `in_ready` is high in cycle N+1.
- `rec_count`, `almost_full` and `empty` are combinational from registered pointers and glitch-free at edges.
- `rst_n` deassertion must be synchronised to `clk` externally.

## Structure
- `record_fifo_pkg`: a function that derives `CountW`/`LevelW` from the parameters. Record payload and count stay parameter-sized in the module; there is no fixed-width package typedef.
- Sub-module `record_packer`: assembly register, `pack_cnt`, zero-padding and commit strobe. It emits `{record, words}` plus `commit`.
- Top level: pointers, a `Depth` × (`RecordBits`+`CountW`) storage array without reset, the output mux and flags.

## Test plan
Run at defaults (8/16/8, threshold 7):
- Reset, then 16 words 0x00..0x0F → `out_valid` in cycle after 16th accept; `out_data[7:0]=0x00`, `out_data[127:120]=0x0F`, `out_words=16`.
- 3 words 0xA1,0xA2,0xA3 with `in_last` on 0xA3 → `out_words=3`, bits[23:0]=0xA3A2A1, bits[127:24]=0.
- `out_ready=0`, stream 128 words → `almost_full` after 7th record; `rec_count=8`, `in_ready=0`; the 129th word is not accepted. Pop once → `in_ready=1` next cycle and the 129th word is accepted.
- `in_valid`/`out_ready` held high for 1000 random words with random `in_last` → records match the scoreboard, order preserved, wraps exercised, no `rec_count` excursion beyond 8.
- 5 words queued, then `clear` (and separately `rst_n` low mid-record) → `rec_count=0`, `out_valid=0`. The next 16-word record starts at word 0 with no stale data.
- `rec_count=4` with a same-cycle commit and pop → `rec_count` stays 4; the popped and committed records are both correct.
